// File: rtl/param_shift_register.sv
// WIDTH-bit universal shift register: load, left/right shift and rotate, plus a burst engine.
// Optional SHREG_ARITH_EN macro adds an 'arith' input that sign-extends right shifts.
module param_shift_register #(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] par_in,
  input  logic             shift_en,
  input  logic             dir,
  input  logic             rotate,
  input  logic             ser_in,
  input  logic             start,
  input  logic [CNT_W-1:0] shift_cnt,
`ifdef SHREG_ARITH_EN
  input  logic             arith,
`endif
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               dir_q, dir_d;
  logic               rot_q, rot_d;

  logic               eff_dir;
  logic               eff_rot;
  logic               eff_arith;
  logic               fill;
  logic [WIDTH-1:0]   shifted;

  // A running burst uses the mode captured at start; otherwise the live pins decide.
  assign eff_dir = (state_q == ST_SHIFT) ? dir_q : dir;
  assign eff_rot = (state_q == ST_SHIFT) ? rot_q : rotate;

`ifdef SHREG_ARITH_EN
  logic arith_q, arith_d;
  assign eff_arith = (state_q == ST_SHIFT) ? arith_q : arith;
`else
  assign eff_arith = 1'b0;
`endif

  always_comb begin
    fill = ser_in;
    if (eff_rot) begin
      fill = eff_dir ? shreg_q[WIDTH-1] : shreg_q[0];
    end else if (eff_arith && !eff_dir) begin
      fill = shreg_q[WIDTH-1];
    end
  end

  assign shifted = eff_dir ? {shreg_q[WIDTH-2:0], fill}
                           : {fill, shreg_q[WIDTH-1:1]};

  always_comb begin
    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    state_d     = state_q;
    shreg_d     = shreg_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    rot_d       = rot_q;
`ifdef SHREG_ARITH_EN
    arith_d     = arith_q;
`endif

    if (load) begin
      // Load overrides everything below reset and also aborts a burst without a done pulse.
      shreg_d     = par_in;
      state_d     = ST_IDLE;
      remaining_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (shift_cnt != '0) begin
              state_d     = ST_SHIFT;
              remaining_d = shift_cnt;
              dir_d       = dir;
              rot_d       = rotate;
`ifdef SHREG_ARITH_EN
              arith_d     = arith;
`endif
            end else begin
              state_d = ST_DONE;
            end
          end else if (shift_en) begin
            shreg_d = shifted;
          end
        end

        ST_SHIFT: begin
          shreg_d     = shifted;
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
          if (shift_en) begin
            shreg_d = shifted;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= RESET_VAL;
      remaining_q <= '0;
      dir_q       <= 1'b0;
      rot_q       <= 1'b0;
`ifdef SHREG_ARITH_EN
      arith_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      rot_q       <= rot_d;
`ifdef SHREG_ARITH_EN
      arith_q     <= arith_d;
`endif
    end
  end

  assign q       = shreg_q;
  assign ser_out = eff_dir ? shreg_q[WIDTH-1] : shreg_q[0];
  assign busy    = (state_q == ST_SHIFT);
  assign done    = (state_q == ST_DONE);

endmodule
